// File: rtl/adder_sequencer.sv
// adder_sequencer: handshake front/back end around an external combinational
// ripple-carry adder. Operands are accepted on an in_valid/in_ready handshake,
// held on the adder inputs for SETTLE_CYCLES clocks, then the sum/carry are
// registered and offered on an out_valid/out_ready handshake.
// Optional feature macro: ADDER_SEQ_OVF_EN adds a registered signed-overflow
// flag (out_ovf) captured together with the sum.
module adder_sequencer #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef ADDER_SEQ_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Counter reload: the capture edge is SETTLE_CYCLES edges after accept.
  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             in_ready_s;
  logic             accept_s;

`ifdef ADDER_SEQ_OVF_EN
  logic             ovf_q, ovf_d;

  // Two's-complement overflow: operands agree in sign, sum sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction
`endif

  // A new pair may enter when idle, or when the held result leaves this edge.
  assign in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_s   = in_valid && in_ready_s;

  // Next-state, operand hold and result capture decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
`ifdef ADDER_SEQ_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          add_a_d = in_a;
          add_b_d = in_b;
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        // in_valid is deliberately ignored while the ripple settles.
        if (cnt_q == 8'd0) begin
          sum_d   = add_s;
          cout_d  = add_cout;
`ifdef ADDER_SEQ_OVF_EN
          ovf_d   = signed_ovf(add_a_q[WIDTH-1], add_b_q[WIDTH-1], add_s[WIDTH-1]);
`endif
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            // Back-to-back: the result leaves and the next pair loads together.
            add_a_d = in_a;
            add_b_d = in_b;
            cnt_d   = CNT_LOAD;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_SETTLE);
  end

  // State, counter, operand and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_s;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
`ifdef ADDER_SEQ_OVF_EN
  assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_adder_sequencer.sv
// Scoreboard bench for adder_sequencer. A driver issues directed and random
// operand pairs and pushes the expected result (sum, carry, overflow, accept
// edge, capture edge) into a queue; a monitor compares the DUT against the
// queue head every cycle. The external adder is modelled behaviourally.
module tb_adder_sequencer;

  localparam int W      = 16;
  localparam int SETTLE = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] add_a, add_b, add_s;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
`ifdef ADDER_SEQ_OVF_EN
  logic         out_ovf;
`endif

  adder_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
`ifdef ADDER_SEQ_OVF_EN
    .out_ovf(out_ovf),
`endif
    .busy(busy)
  );

  // External combinational adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a, b, sum;
    logic         cout, ovf;
    int           acc, due;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] last_sum  = '0;
  logic         last_cout = 1'b0;
  logic         last_ovf  = 1'b0;
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference: result of the pair, computed from the arithmetic definition.
  function automatic exp_t make_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int unsigned full;
    int signed   sa, sb_v, ss;
    full   = int'(a) + int'(b);
    e.a    = a;
    e.b    = b;
    e.sum  = full[W-1:0];
    e.cout = full[W];
    sa     = int'($signed(a));
    sb_v   = int'($signed(b));
    ss     = sa + sb_v;
    e.ovf  = (ss > 32767) || (ss < -32768);
    e.acc  = 0;
    e.due  = 0;
    return e;
  endfunction

  // One cycle of stimulus at the falling edge; acceptance decided by the model.
  task automatic drive_cycle(input bit v, input logic [W-1:0] a,
                             input logic [W-1:0] b, input bit ordy);
    bit   ir_exp;
    exp_t e;
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
    ir_exp = (sb.size() == 0) || ((cyc >= sb[sb.size()-1].due) && ordy);
    check(in_ready == ir_exp, "in_ready", 32'(in_ready), 32'(ir_exp));
    if (v && ir_exp) begin
      e     = make_exp(a, b);
      e.acc = cyc + 1;
      e.due = cyc + 1 + SETTLE;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < SETTLE + 4; i++) begin
      if (sb.size() != 0 && cyc + 1 >= sb[0].due) break;
      drive_cycle(1'b0, '0, '0, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    last_sum  = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    #1;
    check(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
    check(in_ready == 1'b1, "rst_in_ready", 32'(in_ready), 32'd1);
    check(busy == 1'b0, "rst_busy", 32'(busy), 32'd0);
    check(add_a == '0, "rst_add_a", 32'(add_a), 32'd0);
    check(add_b == '0, "rst_add_b", 32'(add_b), 32'd0);
    check(out_sum == '0, "rst_out_sum", 32'(out_sum), 32'd0);
    check(out_cout == 1'b0, "rst_out_cout", 32'(out_cout), 32'd0);
`ifdef ADDER_SEQ_OVF_EN
    check(out_ovf == 1'b0, "rst_out_ovf", 32'(out_ovf), 32'd0);
`endif
  endtask

  // Monitor: compares DUT outputs with the scoreboard head every cycle.
  always @(negedge clk) begin
    bit ov_exp, busy_exp;
    #2;
    if (!rst) begin
      ov_exp   = (sb.size() != 0) && (cyc >= sb[0].due);
      busy_exp = (sb.size() != 0) && (cyc >= sb[0].acc) && (cyc < sb[0].due);
      check(out_valid == ov_exp, "out_valid", 32'(out_valid), 32'(ov_exp));
      check(busy == busy_exp, "busy", 32'(busy), 32'(busy_exp));
      if (busy_exp) begin
        check(add_a == sb[0].a, "add_a", 32'(add_a), 32'(sb[0].a));
        check(add_b == sb[0].b, "add_b", 32'(add_b), 32'(sb[0].b));
      end
      if (ov_exp) begin
        check(out_sum == sb[0].sum, "out_sum", 32'(out_sum), 32'(sb[0].sum));
        check(out_cout == sb[0].cout, "out_cout", 32'(out_cout), 32'(sb[0].cout));
`ifdef ADDER_SEQ_OVF_EN
        check(out_ovf == sb[0].ovf, "out_ovf", 32'(out_ovf), 32'(sb[0].ovf));
`endif
        last_sum  = sb[0].sum;
        last_cout = sb[0].cout;
        last_ovf  = sb[0].ovf;
        if (out_ready) void'(sb.pop_front());
      end else begin
        check(out_sum == last_sum, "out_sum_hold", 32'(out_sum), 32'(last_sum));
        check(out_cout == last_cout, "out_cout_hold", 32'(out_cout), 32'(last_cout));
`ifdef ADDER_SEQ_OVF_EN
        check(out_ovf == last_ovf, "out_ovf_hold", 32'(out_ovf), 32'(last_ovf));
`endif
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    do_reset();

    // 15 + 15, then hold the result unconsumed for 10 cycles while (1,2) waits.
    drive_cycle(1'b1, 16'd15, 16'd15, 1'b0);
    wait_done();
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 16'd1, 16'd2, 1'b0);
    drive_cycle(1'b0, '0, '0, 1'b1);

    // Carry out of the top bit, then back-to-back accept in the DONE cycle.
    drive_cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    wait_done();
    drive_cycle(1'b1, 16'h1234, 16'h1111, 1'b1);
    wait_done();
    drive_cycle(1'b0, '0, '0, 1'b1);

    // Signed overflow boundary and its negative counterpart.
    drive_cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    wait_done();
    drive_cycle(1'b1, 16'h8000, 16'h8000, 1'b1);
    wait_done();
    drive_cycle(1'b0, '0, '0, 1'b1);

    // Random traffic with a randomly stalling consumer.
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 2) != 0, W'($urandom), W'($urandom),
                  $urandom_range(0, 3) != 0);
    end

    // Reset in the middle of SETTLE: no capture may follow.
    for (int i = 0; i < 2 * SETTLE + 4 && sb.size() != 0; i++)
      drive_cycle(1'b0, '0, '0, 1'b1);
    drive_cycle(1'b1, 16'h00AA, 16'h0055, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, '0, 1'b0);
    do_reset();
    for (int i = 0; i < SETTLE + 6; i++) drive_cycle(1'b0, '0, '0, 1'b1);

    // A final transaction after reset, then drain with a bounded budget.
    drive_cycle(1'b1, 16'h4000, 16'h4000, 1'b1);
    for (int i = 0; i < 2 * SETTLE + 8 && sb.size() != 0; i++)
      drive_cycle(1'b0, '0, '0, 1'b1);
    check(sb.size() == 0, "drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
